// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Main control unit of the multicycle RV32I datapath. A Moore FSM steps
// each instruction through fetch / decode / execute / memory / writeback
// (3 to 5 cycles). It drives every datapath enable and mux select, and it
// drives imm_src to the immediate sign-extender downstream.
//
// Build option: define ILLEGAL_TRAP_EN to park unsupported opcodes in a
// TRAP state and to add the illegal_instr output. With the macro undefined,
// unsupported opcodes return to FETCH and behave as a NOP.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   op/funct3/funct7b5  instruction fields from the instruction register
//   zero           ALU zero flag (branch resolution)
//   pc_write, adr_src, mem_write, ir_write, reg_write   enables / selects
//   result_src, alu_src_a, alu_src_b, alu_control       mux selects / ALU op
//   imm_src        immediate format (I/S/B/J) for the sign-extender
//   state_o        current state (debug)
//   illegal_instr  high while trapped (ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic [STATE_W-1:0] state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal_instr
`endif
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(4'd0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(4'd1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(4'd2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(4'd3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4'd4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(4'd5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(4'd6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(4'd7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(4'd8);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(4'd9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(4'd10);
`ifdef ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(4'd11);
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] next_state_s;
    logic [1:0]         aluop_s;
    logic               pc_update_s;
    logic               branch_s;

    // State register; reset returns to FETCH at once, aborting any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE:          next_state_s = S_EXECUTER;
                    OP_ITYPE:          next_state_s = S_EXECUTEI;
                    OP_BEQ:            next_state_s = S_BEQ;
                    OP_JAL:            next_state_s = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state_s = S_TRAP;
`else
                    default:           next_state_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_JAL:      next_state_s = S_ALUWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BEQ:      next_state_s = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            // Trap is sticky; only rst_n leaves it.
            S_TRAP:     next_state_s = S_TRAP;
`endif
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore outputs per state; anything not set here stays 0.
    always_comb begin
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        aluop_s     = ALUOP_ADD;
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write    = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                pc_update_s = 1'b1;
            end
            S_DECODE: begin
                // Branch target PC+imm is precomputed here into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                aluop_s   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop_s   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop_s   = ALUOP_SUB;
                branch_s  = 1'b1;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                pc_update_s = 1'b1;
            end
            default: begin
                aluop_s = ALUOP_ADD;
            end
        endcase
    end

    // ALU decoder; only R-type with funct7b5 subtracts (addi never does).
    always_comb begin
        alu_control = 3'b000;
        case (aluop_s)
            ALUOP_ADD: alu_control = 3'b000;
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] & funct7b5) begin
                            alu_control = 3'b001;
                        end else begin
                            alu_control = 3'b000;
                        end
                    end
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format follows op in every state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    assign pc_write = pc_update_s | (branch_s & zero);
    assign state_o  = state_r;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_r == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: steps each instruction class through
// its state sequence and checks outputs against hand-derived values.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int vectors;
    int miscompares;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_write(reg_write), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #3;
        vectors++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%0d mw=%b rw=%b, want 0 0 0", state_o, mem_write, reg_write);
        end
        vectors++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b10 || result_src !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_fetch_outs: irw=%b pcw=%b b=%b rs=%b, want 1 1 10 10",
                     ir_write, pc_write, alu_src_b, result_src);
        end
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_lw();
        int exp_st [6] = '{0, 1, 2, 3, 4, 0};
        op = 7'b0000011;
        #1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (state_o !== 4'(exp_st[i]) || imm_src !== 2'b00 ||
                reg_write !== (exp_st[i] == 4) || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL lw_step%0d: state=%0d imm=%b rw=%b mw=%b, want state=%0d imm=00 rw=%b mw=0",
                         i, state_o, imm_src, reg_write, mem_write, exp_st[i], (exp_st[i] == 4));
            end
            if (exp_st[i] == 4) begin
                vectors++;
                if (result_src !== 2'b01) begin
                    miscompares++;
                    $display("FAIL lw_memwb_result_src: got %b want 01", result_src);
                end
            end
            if (exp_st[i] == 3) begin
                vectors++;
                if (adr_src !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lw_memread_adr_src: got %b want 1", adr_src);
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        int exp_st [5] = '{0, 1, 2, 5, 0};
        op = 7'b0100011;
        #1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state_o !== 4'(exp_st[i]) || imm_src !== 2'b01 ||
                mem_write !== (exp_st[i] == 5) || reg_write !== 1'b0) begin
                miscompares++;
                $display("FAIL sw_step%0d: state=%0d imm=%b mw=%b rw=%b, want state=%0d imm=01 mw=%b rw=0",
                         i, state_o, imm_src, mem_write, reg_write, exp_st[i], (exp_st[i] == 5));
            end
            if (exp_st[i] == 5) begin
                vectors++;
                if (adr_src !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sw_adr_src: got %b want 1", adr_src);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        vectors++;
        if (state_o !== 4'd6 || alu_control !== 3'b001 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
            miscompares++;
            $display("FAIL rtype_sub: state=%0d alu=%b a=%b b=%b, want 6 001 10 00",
                     state_o, alu_control, alu_src_a, alu_src_b);
        end
        funct3 = 3'b111; #1;
        vectors++;
        if (alu_control !== 3'b010) begin
            miscompares++;
            $display("FAIL rtype_and: got %b want 010", alu_control);
        end
        funct3 = 3'b010; #1;
        vectors++;
        if (alu_control !== 3'b101) begin
            miscompares++;
            $display("FAIL rtype_slt: got %b want 101", alu_control);
        end
        funct3 = 3'b110; #1;
        vectors++;
        if (alu_control !== 3'b011) begin
            miscompares++;
            $display("FAIL rtype_or: got %b want 011", alu_control);
        end
        tick();
        vectors++;
        if (state_o !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00) begin
            miscompares++;
            $display("FAIL rtype_aluwb: state=%0d rw=%b rs=%b, want 8 1 00", state_o, reg_write, result_src);
        end
        tick();
        vectors++;
        if (state_o !== 4'd0) begin
            miscompares++;
            $display("FAIL rtype_return: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_itype();
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        vectors++;
        if (state_o !== 4'd7 || alu_control !== 3'b000 || alu_src_b !== 2'b01) begin
            miscompares++;
            $display("FAIL itype_addi: state=%0d alu=%b b=%b, want 7 000 01", state_o, alu_control, alu_src_b);
        end
        tick(); tick();
        vectors++;
        if (state_o !== 4'd0) begin
            miscompares++;
            $display("FAIL itype_return: state=%0d want 0", state_o);
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_beq();
        op = 7'b1100011; zero = 1'b1;
        tick(); tick();
        vectors++;
        if (state_o !== 4'd9 || imm_src !== 2'b10 || alu_control !== 3'b001 || pc_write !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_taken: state=%0d imm=%b alu=%b pcw=%b, want 9 10 001 1",
                     state_o, imm_src, alu_control, pc_write);
        end
        zero = 1'b0; #1;
        vectors++;
        if (pc_write !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_not_taken: pcw=%b want 0", pc_write);
        end
        tick();
        vectors++;
        if (state_o !== 4'd0) begin
            miscompares++;
            $display("FAIL beq_return: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_jal();
        op = 7'b1101111;
        tick(); tick();
        vectors++;
        if (state_o !== 4'd10 || imm_src !== 2'b11 || pc_write !== 1'b1 ||
            alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin
            miscompares++;
            $display("FAIL jal_state: state=%0d imm=%b pcw=%b a=%b b=%b, want 10 11 1 01 10",
                     state_o, imm_src, pc_write, alu_src_a, alu_src_b);
        end
        tick();
        vectors++;
        if (state_o !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00 || pc_write !== 1'b0) begin
            miscompares++;
            $display("FAIL jal_wb: state=%0d rw=%b rs=%b pcw=%b, want 8 1 00 0",
                     state_o, reg_write, result_src, pc_write);
        end
        tick();
        vectors++;
        if (state_o !== 4'd0) begin
            miscompares++;
            $display("FAIL jal_return: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_reset_mid();
        op = 7'b0000011;
        tick(); tick(); tick();
        vectors++;
        if (state_o !== 4'd3) begin
            miscompares++;
            $display("FAIL mid_setup: state=%0d want 3", state_o);
        end
        rst_n = 1'b0; #1;
        vectors++;
        if (state_o !== 4'd0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: state=%0d rw=%b mw=%b, want 0 0 0", state_o, reg_write, mem_write);
        end
        tick();
        rst_n = 1'b1; #1;
    endtask

    task automatic test_illegal();
        op = 7'b0000000;
        tick();
        vectors++;
        if (state_o !== 4'd1) begin
            miscompares++;
            $display("FAIL illegal_decode: state=%0d want 1", state_o);
        end
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (state_o !== 4'd11 || illegal_instr !== 1'b1 || pc_write !== 1'b0 ||
                mem_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_trap%0d: state=%0d ill=%b pcw=%b mw=%b rw=%b irw=%b, want 11 1 0 0 0 0",
                         i, state_o, illegal_instr, pc_write, mem_write, reg_write, ir_write);
            end
            tick();
        end
        rst_n = 1'b0; #1;
        vectors++;
        if (state_o !== 4'd0 || illegal_instr !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_trap_exit: state=%0d ill=%b, want 0 0", state_o, illegal_instr);
        end
        rst_n = 1'b1;
`else
        vectors++;
        if (state_o !== 4'd0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_nop: state=%0d rw=%b mw=%b, want 0 0 0", state_o, reg_write, mem_write);
        end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_beq();
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multicycle RV32I datapath; sits directly upstream of the immediate sign-extender.
- Decodes op/funct3/funct7b5 of the instruction register and drives imm_src[1:0] into the extender, alongside all datapath enables and mux selects.
- Moore FSM sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.

Parameters:
STATE_W, 4, width of state register and state_o debug port (minimum 4).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0=PC, 1=ALU result register
mem_write  output  1  data memory write enable
ir_write  output  1  instruction/oldPC register enable
result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 data
alu_src_b  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  00 I, 01 S, 10 B, 11 J (to sign-extender)
reg_write  output  1  register file write enable
state_o  output  STATE_W  current state (debug)

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on rst_n. rst_n low forces state=FETCH immediately, including mid-instruction; no partial writes follow.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- All outputs are combinational from state plus op/funct/zero; no output registers.
- While in reset, outputs equal the FETCH values. mem_write and reg_write are 0 in reset.
- Every output not listed for a state is 0.
- Per-state outputs:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, aluop=add, result_src=10, pc_update=1.
  - DECODE: a=01, b=01, aluop=add (branch target precompute).
  - MEMADR: a=10, b=01, add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - EXECUTER: a=10, b=00, aluop=funct.
  - EXECUTEI: a=10, b=01, aluop=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, aluop=sub, result_src=00, branch=1.
  - JAL: a=01, b=10, add, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & zero).
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, any other->illegal handling.
  - MEMADR: op=0000011->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECUTER/EXECUTEI/JAL->ALUWB.
  - MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
  - Undefined state codes->FETCH.
- Latency in cycles: lw 5; sw, R, I, jal 4; beq 3.
- alu_control:
  - aluop add->000; sub->001.
  - aluop funct by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010->101; 110->011; 111->010; other funct3->000.
  - addi never subtracts regardless of funct7b5.
- imm_src from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
- op, funct3, funct7b5 come from the instruction register, which is stable from DECODE onward.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: DECODE with unsupported op -> TRAP. TRAP holds all enables 0 and stays until rst_n. Adds output illegal_instr (1 bit), high only in TRAP.
- Undefined: unsupported op in DECODE -> FETCH (executes as NOP, 2 cycles). TRAP code unused; no illegal_instr port.

Test Plan:
- Reset: rst_n=0 -> state_o=0, mem_write=0, reg_write=0. Release, op=0000011 (lw) -> states 0,1,2,3,4,0. imm_src=00 throughout. reg_write=1 only in state 4, result_src=01 there.
- sw: op=0100011 -> states 0,1,2,5,0. mem_write=1 exactly one cycle (state 5), adr_src=1. imm_src=01.
- R-type: op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in state 6. Same with op=0010011 -> alu_control=000 in state 7. funct3=111 -> 010.
- beq: op=1100011 -> imm_src=10, alu_control=001 in state 9. zero=1 -> pc_write=1; zero=0 -> pc_write=0. Next state 0.
- jal: op=1101111 -> imm_src=11, states 0,1,10,8,0. pc_write=1 in state 10; reg_write=1 in state 8 with result_src=00.
- Reset mid-op: rst_n low during state 3 -> state_o=0 before the next clk edge. op=0000000 -> FETCH after DECODE (macro off), or TRAP with illegal_instr=1 held (macro on).
